// File: rtl/bus_book_pkg.sv
// ============================================================================
// bus_book_pkg : shared types, default sizes and helpers for seat allocation
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_book_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CHECK = 1'b1
  } state_t;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_NSEATS   = 32;
  localparam int DEF_HOLD_CYC = 16;

  // Widest bitmap popcount accepts; narrower maps are zero-extended by callers.
  localparam int POP_MAX = 256;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin picker starting the search at ptr
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic found;
    int   cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/seat_alloc_ctrl.sv
// ============================================================================
// seat_alloc_ctrl : round-robin seat-hold arbiter with timed holds, bookings
//                   and live occupancy bitmaps for one bus
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seat_alloc_ctrl
  import bus_book_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int NSEATS   = DEF_NSEATS,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int SW       = $clog2(NSEATS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*SW-1:0]          req_seat,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             resp_valid,
  output logic                        resp_ok,
  output logic [SW-1:0]               resp_seat,
  input  logic [NREQ-1:0]             confirm,
  input  logic [NREQ-1:0]             cancel,
  output logic [NREQ-1:0]             expire,
  output logic [NSEATS-1:0]           seat_booked,
  output logic [NSEATS-1:0]           seat_held,
  output logic [$clog2(NSEATS+1)-1:0] free_count,
  output logic                        sold_out
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(HOLD_CYC);
  localparam int CW = $clog2(NSEATS+1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(HOLD_CYC - 1);
  localparam logic [SW:0]   SEAT_LIMIT = (SW+1)'(NSEATS);
  localparam logic [IW-1:0] LAST_REQ   = IW'(NREQ - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, win_idx;
  logic [SW-1:0]   win_seat;
  logic [NREQ-1:0] hold_valid;
  logic [SW-1:0]   hold_seat  [NREQ];
  logic [TW-1:0]   hold_timer [NREQ];
  logic [SW-1:0]   seat_of    [NREQ];

  logic [NREQ-1:0] eligible, arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            grant_fire, check_fire, seat_free;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign seat_of[gi] = req_seat[gi*SW +: SW];
  end

  assign eligible = req_valid & ~hold_valid;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb_any) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Availability is judged on the bitmaps as they stand before this edge.
  always_comb begin
    grant_fire = (state == S_IDLE) && arb_any;
    check_fire = (state == S_CHECK);
    seat_free  = ({1'b0, win_seat} < SEAT_LIMIT) &&
                 !seat_booked[win_seat] && !seat_held[win_seat];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      win_idx     <= '0;
      win_seat    <= '0;
      hold_valid  <= '0;
      seat_booked <= '0;
      seat_held   <= '0;
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_ok     <= 1'b0;
      resp_seat   <= '0;
      expire      <= '0;
      for (int i = 0; i < NREQ; i++) begin
        hold_seat[i]  <= '0;
        hold_timer[i] <= '0;
      end
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      expire     <= '0;

      if (grant_fire) begin
        win_idx   <= arb_idx;
        win_seat  <= seat_of[arb_idx];
        req_ready <= arb_gnt;
      end

      for (int i = 0; i < NREQ; i++) begin
        if (hold_valid[i]) begin
          if (confirm[i]) begin
            seat_booked[hold_seat[i]] <= 1'b1;
            seat_held[hold_seat[i]]   <= 1'b0;
            hold_valid[i]             <= 1'b0;
          end else if (cancel[i] || (hold_timer[i] == '0)) begin
            seat_held[hold_seat[i]] <= 1'b0;
            hold_valid[i]           <= 1'b0;
            expire[i]               <= !cancel[i];
          end else begin
            hold_timer[i] <= hold_timer[i] - 1'b1;
          end
        end
      end

      // The winner cannot own a hold here, so this never collides with the loop above.
      if (check_fire) begin
        resp_valid[win_idx] <= 1'b1;
        resp_ok             <= seat_free;
        resp_seat           <= win_seat;
        rr_ptr              <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
        if (seat_free) begin
          seat_held[win_seat]  <= 1'b1;
          hold_valid[win_idx]  <= 1'b1;
          hold_seat[win_idx]   <= win_seat;
          hold_timer[win_idx]  <= TIMER_INIT;
        end
      end
    end
  end

  assign free_count = CW'(NSEATS - int'(popcount(POP_MAX'(seat_booked | seat_held))));
  assign sold_out   = (free_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_seat_alloc_ctrl.sv
// ============================================================================
// tb_seat_alloc_ctrl : randomized scoreboard bench against a seat-level model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seat_alloc_ctrl;
  import bus_book_pkg::*;

  localparam int NREQ     = 4;
  localparam int NSEATS   = 32;
  localparam int HOLD_CYC = 16;
  localparam int SW       = $clog2(NSEATS);
  localparam int CW       = $clog2(NSEATS+1);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid, confirm, cancel, expire;
  logic [NREQ*SW-1:0]  req_seat;
  logic                resp_ok, sold_out;
  logic [SW-1:0]       resp_seat;
  logic [NSEATS-1:0]   seat_booked, seat_held;
  logic [CW-1:0]       free_count;

  always #5 clk = ~clk;

  seat_alloc_ctrl #(.NREQ(NREQ), .NSEATS(NSEATS), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_seat(req_seat), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_seat(resp_seat),
    .confirm(confirm), .cancel(cancel), .expire(expire),
    .seat_booked(seat_booked), .seat_held(seat_held),
    .free_count(free_count), .sold_out(sold_out)
  );

  typedef struct { int idx; bit ok; int seat; } resp_t;
  resp_t sb[$];

  int tests = 0;
  int fails = 0;

  // Model: seat_st 0=free 1=held 2=booked; hold_of = seat held by requester or -1.
  int              seat_st [NSEATS];
  int              hold_of [NREQ];
  longint          deadline[NREQ];
  bit              pending;
  int              p_win, p_seat, rr;
  longint          edge_no;
  logic [NREQ-1:0] exp_ready, exp_expire;
  bit              exp_resp;
  bit              mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_step();
    bit placed;
    int pw, ps, i;
    resp_t r;
    placed = 1'b0; pw = 0; ps = 0;
    exp_ready = '0; exp_expire = '0; exp_resp = 1'b0;
    if (rst) begin
      for (int s = 0; s < NSEATS; s++) seat_st[s] = 0;
      for (int k = 0; k < NREQ; k++) hold_of[k] = -1;
      pending = 1'b0;
      rr      = 0;
    end else begin
      if (pending) begin
        r.idx  = p_win;
        r.seat = p_seat;
        r.ok   = (p_seat < NSEATS) && (seat_st[p_seat] == 0);
        sb.push_back(r);
        exp_resp = 1'b1;
        rr       = (p_win + 1) % NREQ;
        pending  = 1'b0;
        if (r.ok) begin placed = 1'b1; pw = p_win; ps = p_seat; end
      end else begin
        for (int off = 0; off < NREQ; off++) begin
          i = (rr + off) % NREQ;
          if (!pending && req_valid[i] && hold_of[i] < 0) begin
            pending      = 1'b1;
            p_win        = i;
            p_seat       = int'(req_seat[i*SW +: SW]);
            exp_ready[i] = 1'b1;
          end
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (hold_of[k] >= 0) begin
          if (confirm[k]) begin
            seat_st[hold_of[k]] = 2; hold_of[k] = -1;
          end else if (cancel[k]) begin
            seat_st[hold_of[k]] = 0; hold_of[k] = -1;
          end else if (edge_no == deadline[k]) begin
            seat_st[hold_of[k]] = 0; hold_of[k] = -1; exp_expire[k] = 1'b1;
          end
        end
      end
      if (placed) begin
        seat_st[ps]  = 1;
        hold_of[pw]  = ps;
        deadline[pw] = edge_no + HOLD_CYC;
      end
    end
    edge_no++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) if (exp_ready[k]) req_valid[k] = 1'b0;
    confirm = '0;
    cancel  = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic request(input int who, input int seat);
    req_valid[who]            = 1'b1;
    req_seat[who*SW +: SW]    = SW'(seat);
  endtask

  always @(posedge clk) begin : monitor
    logic [NSEATS-1:0] eb, eh;
    logic [NREQ-1:0]   onehot;
    int                nfree;
    resp_t             r;
    #1;
    if (mon_en) begin
      eb = '0; eh = '0; nfree = 0;
      for (int s = 0; s < NSEATS; s++) begin
        if (seat_st[s] == 2)      eb[s] = 1'b1;
        else if (seat_st[s] == 1) eh[s] = 1'b1;
        else                      nfree++;
      end
      chk("seat_booked", 64'(seat_booked), 64'(eb));
      chk("seat_held",   64'(seat_held),   64'(eh));
      chk("free_count",  64'(free_count),  64'(nfree));
      chk("sold_out",    64'(sold_out),    64'(nfree == 0));
      chk("req_ready",   64'(req_ready),   64'(exp_ready));
      chk("expire",      64'(expire),      64'(exp_expire));
      chk("resp_present", 64'(|resp_valid), 64'(exp_resp));
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected @%0t: got resp_valid=%0h expected none", $time, resp_valid);
        end else begin
          r = sb.pop_front();
          onehot = '0;
          onehot[r.idx] = 1'b1;
          chk("resp_idx",  64'(resp_valid), 64'(onehot));
          chk("resp_ok",   64'(resp_ok),    64'(r.ok));
          chk("resp_seat", 64'(resp_seat),  64'(r.seat));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_seat = '0; confirm = '0; cancel = '0;
    for (int s = 0; s < NSEATS; s++) seat_st[s] = 0;
    for (int k = 0; k < NREQ; k++) begin hold_of[k] = -1; deadline[k] = 0; end
    pending = 1'b0; p_win = 0; p_seat = 0; rr = 0; edge_no = 0;
    exp_ready = '0; exp_expire = '0; exp_resp = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    run(2); rst = 1'b0; run(3);

    // Single hold on seat 5.
    request(0, 5); run(3);

    // Collision on seat 7 with rr_ptr=0, then again with rr_ptr=1.
    rst = 1'b1; run(1); rst = 1'b0;
    request(0, 7); request(1, 7); run(6);
    rst = 1'b1; run(1); rst = 1'b0;
    request(0, 20); run(3); cancel[0] = 1'b1; run(2);
    request(0, 7); request(1, 7); run(6);

    // Confirm turns a hold into a booking; seat then stays unavailable.
    request(2, 3); run(6); confirm[2] = 1'b1; run(2);
    request(1, 3); run(4);

    // Timeout of an unconfirmed hold.
    request(3, 9); run(HOLD_CYC + 6);

    // Confirm wins over cancel.
    request(0, 11); run(4); confirm[0] = 1'b1; cancel[0] = 1'b1; run(2);

    // Reset landing on the check cycle aborts the transaction.
    request(1, 12); run(1); rst = 1'b1; run(1); rst = 1'b0; run(2);

    // Randomized traffic with periodic resets.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] && $urandom_range(99) < 25)
          request(k, ($urandom_range(99) < 70) ? int'($urandom_range(7))
                                               : int'($urandom_range(NSEATS-1)));
        if ($urandom_range(99) < 4) confirm[k] = 1'b1;
        if ($urandom_range(99) < 4) cancel[k]  = 1'b1;
      end
      rst = (c % 300 == 299);
      run(1);
    end
    rst = 1'b0;

    // Book every seat, then everything else is rejected.
    req_valid = '0;
    rst = 1'b1; run(1); rst = 1'b0; run(1);
    for (int s = 0; s < NSEATS; s++) begin
      request(s % NREQ, s); run(3);
      confirm[s % NREQ] = 1'b1; run(1);
    end
    for (int k = 0; k < NREQ; k++) request(k, k * 5 + 1);
    run(12);
    req_valid = '0;
    run(4);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL resp_missing: got %0d undelivered responses expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
